card_dealer: RTL
================

Name: card_dealer

Overview:
- Parametrised successor to the next-address shuffler. It deals card indices from a deck of DECK_SIZE cards and never repeats a card until the deck is reshuffled.
- A free-running counter value is sampled as the entropy seed. A used-card bitmap is kept, and addresses are probed linearly, with wrap-around, until a free card is found.
- Sits between the game FSM, which issues draws and shuffles, and the card ROM address input.

Parameters:
- DECK_SIZE, 52, number of cards in the deck, from 2 to 2**ADDR_W.
- ADDR_W, 6, width of a card index.
- CNT_W, 12, width of the entropy counter input.

Ports:
- clk_2K  input  1  system clock.
- i_RstDealer  input  1  synchronous reset, active-high.
- i_Cnt  input  CNT_W  free-running counter value used as seed.
- i_Draw  input  1  draw request, sampled only in IDLE.
- i_Shuffle  input  1  clears the used bitmap, restoring the full deck.
- o_Card  output  ADDR_W  dealt card index, held until the next deal.
- o_Valid  output  1  one-cycle pulse: o_Card is newly valid.
- o_Busy  output  1  high while a draw is in progress.
- o_Err  output  1  one-cycle pulse: draw requested on an empty deck.
- o_Empty  output  1  high when o_Remaining == 0.
- o_Remaining  output  ADDR_W+1  cards not yet dealt.

Behaviour:
- Single clock clk_2K. Reset is synchronous and active-high (i_RstDealer), and has priority over every other input.
- Reset values:
  - state = IDLE
  - used bitmap all 0
  - o_Card = 0, o_Valid = 0, o_Busy = 0, o_Err = 0
  - o_Remaining = DECK_SIZE, o_Empty = 0
- FSM states:
  - IDLE:
    - i_Shuffle=1: clear the bitmap and set o_Remaining = DECK_SIZE; stay in IDLE. Shuffle wins over a simultaneous i_Draw, and the draw is dropped.
    - i_Draw=1 and o_Remaining != 0: latch probe address = i_Cnt mod DECK_SIZE, set o_Busy = 1, go to PROBE.
    - i_Draw=1 and o_Remaining == 0: pulse o_Err for one cycle, stay in IDLE, and leave the bitmap unchanged.
  - PROBE (one bitmap lookup per cycle):
    - used[addr]==0: set used[addr] = 1, o_Card = addr, o_Valid = 1 for one cycle, o_Remaining decrements by 1, o_Busy = 0, go to IDLE.
    - used[addr]==1: addr = addr+1, wrapping DECK_SIZE-1 to 0; stay in PROBE.
- Latency: the draw is accepted at edge k. With a free seed card, o_Valid is high in the cycle after edge k+1. Each collision adds one cycle, so the worst case is DECK_SIZE+1 edges. PROBE always terminates because o_Remaining > 0 is guaranteed on entry.
- i_Draw in PROBE is ignored and not queued. The requester must wait for o_Valid.
- i_Shuffle in PROBE aborts the draw:
  - bitmap cleared, o_Remaining = DECK_SIZE
  - no o_Valid pulse, o_Busy = 0, return to IDLE
  - o_Card keeps its last value
- Reset in PROBE: return to reset values on the next edge, with no o_Valid pulse.
- Modulo reduction is performed at full CNT_W width. o_Remaining is ADDR_W+1 bits wide so that it can hold DECK_SIZE = 2**ADDR_W.
- o_Empty is combinational from o_Remaining. All other outputs are registered.

Test Plan:
- Reset check: assert i_RstDealer for 2 cycles, then release. Required: o_Remaining=52, o_Empty=0, o_Valid=0, o_Busy=0, o_Card=0.
- Full deal:
  - Stimulus: 52 draws with random i_Cnt, each waiting for o_Valid.
  - Required: 52 distinct o_Card values covering 0..51; o_Remaining reaches 0; o_Empty=1.
  - A 53rd draw gives an o_Err pulse, no o_Valid, and o_Remaining stays 0.
- Collision:
  - Draw with i_Cnt=5: card 5, o_Valid two edges after acceptance.
  - Draw again with i_Cnt=57 (57 mod 52 = 5): card 6, o_Valid three edges after acceptance.
- Wrap-around: with card 51 used, draw with i_Cnt=51 -> card 0.
- Abort and reset mid-operation:
  - Deal cards 0..50, then draw with i_Cnt=0.
  - Assert i_Shuffle in the second PROBE cycle. Required: no o_Valid, o_Busy=0, o_Remaining=52.
  - Repeat the sequence with i_RstDealer in place of i_Shuffle. Required: the reset values.
- Parameter variant: DECK_SIZE=8, ADDR_W=3, CNT_W=4, with 8 draws at i_Cnt=15. Required: cards 7,0,1,2,3,4,5,6 in that order, and o_Remaining reaches 0.

Source files
------------

// File: rtl/card_dealer_if.sv
// Request/response bundle between the game FSM and the card dealer.
// The master side issues draws and shuffles; the slave side deals card indices.
interface card_dealer_if #(
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 12
);
  logic [CNT_W-1:0]  i_Cnt;
  logic              i_Draw;
  logic              i_Shuffle;
  logic [ADDR_W-1:0] o_Card;
  logic              o_Valid;
  logic              o_Busy;
  logic              o_Err;
  logic              o_Empty;
  logic [ADDR_W:0]   o_Remaining;

  modport master (
    output i_Cnt, i_Draw, i_Shuffle,
    input  o_Card, o_Valid, o_Busy, o_Err, o_Empty, o_Remaining
  );

  modport slave (
    input  i_Cnt, i_Draw, i_Shuffle,
    output o_Card, o_Valid, o_Busy, o_Err, o_Empty, o_Remaining
  );
endinterface

// File: rtl/card_dealer.sv
// Deals non-repeating card indices: seeds from a free-running counter, then probes
// a used-card bitmap linearly (with wrap-around) until a free card is found.
module card_dealer #(
  parameter int DECK_SIZE = 52,
  parameter int ADDR_W    = 6,
  parameter int CNT_W     = 12
) (
  input  logic          clk_2K,
  input  logic          i_RstDealer,
  card_dealer_if.slave  bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  DECK_CNT  = CNT_W'(DECK_SIZE);
  localparam logic [ADDR_W:0]   DECK_REM  = (ADDR_W+1)'(DECK_SIZE);
  localparam logic [ADDR_W:0]   REM_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   REM_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  state_t                state_r, state_s;
  logic [DECK_SIZE-1:0]  used_r, used_s;
  logic [ADDR_W-1:0]     addr_r, addr_s;
  logic [ADDR_W-1:0]     card_r, card_s;
  logic                  valid_r, valid_s;
  logic                  busy_r, busy_s;
  logic                  err_r, err_s;
  logic [ADDR_W:0]       rem_r, rem_s;
  logic [ADDR_W-1:0]     seed_addr_s;
  logic [ADDR_W-1:0]     next_addr_s;

  // Reduce at full counter width so large seeds still land uniformly in the deck.
  assign seed_addr_s = ADDR_W'(bus.i_Cnt % DECK_CNT);
  assign next_addr_s = (addr_r == LAST_ADDR) ? {ADDR_W{1'b0}} : addr_r + ADDR_ONE;

  // Next-state and next-output logic for the IDLE/PROBE dealer FSM.
  always_comb begin
    state_s = state_r;
    used_s  = used_r;
    addr_s  = addr_r;
    card_s  = card_r;
    valid_s = 1'b0;
    busy_s  = busy_r;
    err_s   = 1'b0;
    rem_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (bus.i_Shuffle) begin
          used_s = {DECK_SIZE{1'b0}};
          rem_s  = DECK_REM;
          busy_s = 1'b0;
        end else if (bus.i_Draw) begin
          if (rem_r != REM_ZERO) begin
            addr_s  = seed_addr_s;
            busy_s  = 1'b1;
            state_s = PROBE;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      PROBE: begin
        if (bus.i_Shuffle) begin
          used_s  = {DECK_SIZE{1'b0}};
          rem_s   = DECK_REM;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else if (!used_r[addr_r]) begin
          used_s[addr_r] = 1'b1;
          card_s  = addr_r;
          valid_s = 1'b1;
          rem_s   = rem_r - REM_ONE;
          busy_s  = 1'b0;
          state_s = IDLE;
        end else begin
          addr_s = next_addr_s;
        end
      end
      default: begin
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and registered-output update with synchronous reset priority.
  always_ff @(posedge clk_2K) begin
    if (i_RstDealer) begin
      state_r <= IDLE;
      used_r  <= {DECK_SIZE{1'b0}};
      addr_r  <= {ADDR_W{1'b0}};
      card_r  <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
      rem_r   <= DECK_REM;
    end else begin
      state_r <= state_s;
      used_r  <= used_s;
      addr_r  <= addr_s;
      card_r  <= card_s;
      valid_r <= valid_s;
      busy_r  <= busy_s;
      err_r   <= err_s;
      rem_r   <= rem_s;
    end
  end

  assign bus.o_Card      = card_r;
  assign bus.o_Valid     = valid_r;
  assign bus.o_Busy      = busy_r;
  assign bus.o_Err       = err_r;
  assign bus.o_Remaining = rem_r;
  assign bus.o_Empty     = (rem_r == REM_ZERO);

endmodule
